wb_trace_buffer: RTL
====================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the drop counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port retire_valid, input, 1 bit: a WB-stage instruction completes this cycle (one-cycle pulse per instruction).
REQ-006 The block SHALL have port retire_pc, input, 32 bits: PC of the completing instruction.
REQ-007 The block SHALL have ports retire_wen (input, 1 bit), retire_wdest (input, 5 bits) and retire_wdata (input, 32 bits): the register-file write of the completing instruction.
REQ-008 The block SHALL have port capture_en, input, 1 bit: a retirement is captured only while this is high.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous flush of the FIFO, counters and flags.
REQ-010 The block SHALL have port trace_valid, output, 1 bit: the head entry is available.
REQ-011 The block SHALL have port trace_ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 The block SHALL have port trace_data, output, 70 bits: the head entry {pc[69:38], wen[37], wdest[36:32], wdata[31:0]}.
REQ-013 The block SHALL have port level, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-014 The block SHALL have port drop_cnt, output, CNT_W bits: the number of retirements lost because the FIFO was full.
REQ-015 The block SHALL have port overflow, output, 1 bit: a sticky flag, set on the first drop.

Function
REQ-016 A push SHALL occur when retire_valid and capture_en are high, clear is low, and either level<DEPTH or a pop occurs in the same cycle.
REQ-017 A pop SHALL occur when trace_valid and trace_ready are both high.
REQ-018 A pushed entry SHALL appear on trace_data one cycle after the push at the earliest; there is no combinational fall-through from retire_* to trace_*.
REQ-019 trace_valid SHALL equal (level != 0); trace_data SHALL hold stable while trace_valid is high and trace_ready is low.
REQ-020 Entries SHALL be delivered in push order, with read and write pointers wrapping modulo DEPTH.
REQ-021 On a simultaneous push and pop, level SHALL be unchanged, including when full (the push is accepted) and when level==1 (the new entry becomes the head in the next cycle).
REQ-022 A retirement that arrives while full with no pop SHALL be discarded: drop_cnt increments and saturates at all-ones, overflow is set, and FIFO contents are unchanged.
REQ-023 A retirement that arrives with capture_en low SHALL be ignored and SHALL NOT count as a drop.
REQ-024 clear SHALL take priority over push and pop: in the next cycle level=0, pointers=0, drop_cnt=0, overflow=0, and trace_valid=0.
REQ-025 level SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-026 Asserting reset SHALL immediately force level=0, trace_valid=0, drop_cnt=0, overflow=0 and pointers=0, regardless of clk or any operation in progress.
REQ-027 Storage contents SHALL NOT be reset, and trace_data is don't-care while trace_valid=0.
REQ-028 The first push SHALL be possible on the first clk edge after reset deasserts.

Structure
REQ-029 The shared package SHALL hold the entry field widths and offsets (TRACE_PC_W=32, TRACE_DEST_W=5, TRACE_DATA_W=32, TRACE_ENTRY_W=70) and the entry packing order.
REQ-030 The storage array, pointers and occupancy logic SHALL form one sub-module, trace_fifo, parameterised by width and depth.
REQ-031 Capture qualification, the drop counter and the overflow flag SHALL reside in wb_trace_buffer.

Verification
REQ-032 Single retire test: with pc=0xBFC00000, wen=1, wdest=5, wdata=0x12345678 and trace_ready=1 -> trace_valid is high for exactly one cycle, one cycle later, carrying that packed entry; level returns to 0.
REQ-033 Fill and overflow test: with trace_ready=0, issue 10 consecutive retirements -> level=8, drop_cnt=2, overflow=1, and draining returns the first 8 PCs in order.
REQ-034 Full plus simultaneous push/pop test: with a full FIFO and trace_ready=1 while retire_valid=1 for 5 cycles -> level stays 8, drop_cnt is unchanged, and the output order is preserved.
REQ-035 Backpressure test: hold trace_ready=0 for 3 cycles with trace_valid=1 -> trace_data is stable, and the pop occurs on the cycle trace_ready rises.
REQ-036 capture_en, clear and saturation test: retirements with capture_en=0 produce no push and drop_cnt=0; clear while full gives level=0 and overflow=0 in the next cycle; with CNT_W=4 and 20 drops, drop_cnt=15.
REQ-037 Asynchronous reset test: assert reset mid-cycle while level=5 -> level=0 and trace_valid=0 before the next clk edge.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// ============================================================================
// wb_trace_buffer_pkg : trace entry field widths, offsets and packing helper
// Revision 1.0
// ============================================================================
`default_nettype none

package wb_trace_buffer_pkg;

  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_DEST_W  = 5;
  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_ENTRY_W = TRACE_PC_W + 1 + TRACE_DEST_W + TRACE_DATA_W;

  localparam int TRACE_DATA_LSB = 0;
  localparam int TRACE_DEST_LSB = TRACE_DATA_LSB + TRACE_DATA_W;
  localparam int TRACE_WEN_BIT  = TRACE_DEST_LSB + TRACE_DEST_W;
  localparam int TRACE_PC_LSB   = TRACE_WEN_BIT + 1;

  // Field order here defines the packed layout: pc in the MSBs, wdata in the LSBs.
  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic                    wen;
    logic [TRACE_DEST_W-1:0] wdest;
    logic [TRACE_DATA_W-1:0] wdata;
  } trace_entry_t;

  function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(
    input logic [TRACE_PC_W-1:0]   pc,
    input logic                    wen,
    input logic [TRACE_DEST_W-1:0] wdest,
    input logic [TRACE_DATA_W-1:0] wdata
  );
    trace_entry_t e;
    e.pc    = pc;
    e.wen   = wen;
    e.wdest = wdest;
    e.wdata = wdata;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_buffer_fifo.sv
// ============================================================================
// trace_fifo : circular storage, pointers and occupancy for the trace buffer
// Revision 1.0
// ============================================================================
`default_nettype none

module trace_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic pop;
  logic push;

  assign rd_valid = (level_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign pop      = rd_valid && rd_ready && !clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && !clear && ((level_q != C_FULL) || pop);
  assign push_ok  = push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is intentionally not reset; rd_data is only meaningful when rd_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/wb_trace_buffer.sv
// ============================================================================
// wb_trace_buffer : captures WB-stage retirements into a trace FIFO with drop stats
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       retire_valid,
  input  logic [TRACE_PC_W-1:0]      retire_pc,
  input  logic                       retire_wen,
  input  logic [TRACE_DEST_W-1:0]    retire_wdest,
  input  logic [TRACE_DATA_W-1:0]    retire_wdata,
  input  logic                       capture_en,
  input  logic                       clear,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [TRACE_ENTRY_W-1:0]   trace_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  logic                     push_req;
  logic                     push_ok;
  logic                     drop;
  logic [TRACE_ENTRY_W-1:0] entry;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic                     overflow_q, overflow_d;

  assign push_req = retire_valid && capture_en && !clear;
  assign drop     = push_req && !push_ok;
  assign entry    = pack_entry(retire_pc, retire_wen, retire_wdest, retire_wdata);

  trace_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push_req (push_req),
    .wr_data  (entry),
    .rd_ready (trace_ready),
    .rd_valid (trace_valid),
    .rd_data  (trace_data),
    .level    (level),
    .push_ok  (push_ok)
  );

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire
